// File: rtl/gobou_mem_img_pp.sv
`default_nettype none
// ============================================================================
// gobou_mem_img_pp : ping-pong image buffer with bank swap and background clear
// Rev 1.0
// ============================================================================
module gobou_mem_img_pp #(
  parameter int DWIDTH  = 16,
  parameter int IMGSIZE = 12,
  parameter int OUTREG  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_we,
  input  logic [IMGSIZE-1:0]       mem_addr,
  input  logic signed [DWIDTH-1:0] write_data,
  input  logic                     read_en,
  input  logic [IMGSIZE-1:0]       read_addr,
  output logic signed [DWIDTH-1:0] read_data,
  output logic                     read_valid,
  input  logic                     swap,
  input  logic                     clear,
  output logic                     busy,
  output logic                     fill_sel
);

  localparam int WORDS = 2**IMGSIZE;

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [IMGSIZE-1:0]       cnt_q, cnt_d;
  logic                     pend_q, pend_d;
  logic                     fill_sel_q, fill_sel_d;
  logic                     busy_q, busy_d;
  logic signed [DWIDTH-1:0] rd_s1_q, rd_s1_d;
  logic                     vld_s1_q, vld_s1_d;

  logic                     w_we;
  logic [IMGSIZE-1:0]       w_waddr;
  logic signed [DWIDTH-1:0] w_wdata;

  logic signed [DWIDTH-1:0] bank0 [WORDS];
  logic signed [DWIDTH-1:0] bank1 [WORDS];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    fill_sel_d = fill_sel_q;
    w_we       = 1'b0;
    w_waddr    = mem_addr;
    w_wdata    = write_data;
    case (state_q)
      IDLE: begin
        w_we = mem_we;
        // A held-over swap fires now; a swap coinciding with clear waits for it.
        fill_sel_d = fill_sel_q ^ (pend_q | (swap & ~clear));
        pend_d     = swap & clear;
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        w_we    = 1'b1;
        w_waddr = cnt_q;
        w_wdata = '0;
        cnt_d   = cnt_q + 1'b1;
        pend_d  = pend_q | swap;
        if (cnt_q == {IMGSIZE{1'b1}}) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR) | pend_d;
  end

  // Bank select for the read is captured with the address, so a swap landing
  // while the read is in flight cannot redirect it.
  always_comb begin
    vld_s1_d = read_en;
    rd_s1_d  = rd_s1_q;
    if (read_en) rd_s1_d = fill_sel_q ? bank0[read_addr] : bank1[read_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      fill_sel_q <= 1'b0;
      busy_q     <= 1'b0;
      rd_s1_q    <= '0;
      vld_s1_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      fill_sel_q <= fill_sel_d;
      busy_q     <= busy_d;
      rd_s1_q    <= rd_s1_d;
      vld_s1_q   <= vld_s1_d;
    end
  end

  // Storage is deliberately not reset; a reset mid-clear leaves partial contents.
  always_ff @(posedge clk) begin
    if (w_we) begin
      if (fill_sel_q) bank1[w_waddr] <= w_wdata;
      else            bank0[w_waddr] <= w_wdata;
    end
  end

  generate
    if (OUTREG != 0) begin : g_outreg
      logic signed [DWIDTH-1:0] rd_s2_q, rd_s2_d;
      logic                     vld_s2_q, vld_s2_d;

      always_comb begin
        vld_s2_d = vld_s1_q;
        rd_s2_d  = vld_s1_q ? rd_s1_q : rd_s2_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_s2_q  <= '0;
          vld_s2_q <= 1'b0;
        end else begin
          rd_s2_q  <= rd_s2_d;
          vld_s2_q <= vld_s2_d;
        end
      end

      assign read_data  = rd_s2_q;
      assign read_valid = vld_s2_q;
    end else begin : g_direct
      assign read_data  = rd_s1_q;
      assign read_valid = vld_s1_q;
    end
  endgenerate

  assign busy     = busy_q;
  assign fill_sel = fill_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_gobou_mem_img_pp.sv
`default_nettype none
// ============================================================================
// tb_gobou_mem_img_pp : directed table, corner sequences and random traffic
// Rev 1.0
// ============================================================================
module tb_gobou_mem_img_pp;

  localparam int DW    = 16;
  localparam int AW    = 12;
  localparam int OR    = 1;
  localparam int WORDS = 2**AW;
  localparam int UNK   = 32'h4000_0000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic signed [DW-1:0] write_data;
  logic                 read_en;
  logic [AW-1:0]        read_addr;
  logic signed [DW-1:0] read_data;
  logic                 read_valid;
  logic                 swap;
  logic                 clear;
  logic                 busy;
  logic                 fill_sel;

  gobou_mem_img_pp #(.DWIDTH(DW), .IMGSIZE(AW), .OUTREG(OR)) dut (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr),
    .write_data(write_data), .read_en(read_en), .read_addr(read_addr),
    .read_data(read_data), .read_valid(read_valid), .swap(swap),
    .clear(clear), .busy(busy), .fill_sel(fill_sel)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: two word arrays, a countdown of words left to clear,
  // a pending-swap flag and a queue of read results with their due edge.
  typedef struct { int due; int d; } rd_t;
  int  mdl_mem [2][WORDS];
  bit  m_fill;
  int  clr_left;
  bit  m_pend;
  rd_t mq[$];
  bit  m_valid;
  int  m_data;
  int  edge_n = 0;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fill   = 1'b0;
    clr_left = 0;
    m_pend   = 1'b0;
    mq.delete();
    m_valid  = 1'b0;
    m_data   = 0;
  endtask

  task automatic model_step();
    rd_t e;
    bit  do_swap;
    edge_n++;
    if (rst) begin
      model_reset();
      return;
    end
    if (read_en) begin
      e.due = edge_n + OR;
      e.d   = mdl_mem[m_fill ? 0 : 1][read_addr];
      mq.push_back(e);
    end
    m_valid = 1'b0;
    if (mq.size() > 0 && mq[0].due == edge_n) begin
      m_valid = 1'b1;
      m_data  = mq[0].d;
      void'(mq.pop_front());
    end
    if (clr_left > 0) begin
      mdl_mem[m_fill][WORDS - clr_left] = 0;
      clr_left--;
      if (swap) m_pend = 1'b1;
    end else begin
      if (mem_we) mdl_mem[m_fill][mem_addr] = int'(write_data);
      do_swap = m_pend;
      m_pend  = 1'b0;
      if (swap) begin
        if (clear) m_pend = 1'b1;
        else       do_swap = 1'b1;
      end
      if (do_swap) m_fill = ~m_fill;
      if (clear) clr_left = WORDS;
    end
  endtask

  task automatic check_outputs();
    chk("fill_sel", fill_sel, m_fill);
    chk("busy", busy, ((clr_left > 0) || m_pend) ? 1 : 0);
    chk("read_valid", read_valid, m_valid);
    if (m_data != UNK) chk("read_data", read_data, m_data);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    mem_we = 0; mem_addr = '0; write_data = '0;
    read_en = 0; read_addr = '0; swap = 0; clear = 0;
  endtask

  task automatic async_reset_check();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_fill_sel", fill_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_read_valid", read_valid, 0);
    chk("rst_read_data", read_data, 0);
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit rst; bit we; int addr; int wdata; bit ren; int raddr; bit swp; bit clr;
    bit e_fill; bit e_busy; bit e_valid; int e_data;
  } vec_t;

  function automatic vec_t mk(bit r, bit we, int a, int wd, bit ren, int ra, bit sw, bit cl,
                              bit ef, bit eb, bit ev, int ed);
    vec_t v;
    v.rst = r; v.we = we; v.addr = a; v.wdata = wd; v.ren = ren; v.raddr = ra;
    v.swp = sw; v.clr = cl; v.e_fill = ef; v.e_busy = eb; v.e_valid = ev; v.e_data = ed;
    return v;
  endfunction

  initial begin
    vec_t tbl[6];
    int   busy_cnt, vcnt, nz, f0, prev_f, toggles, toggle_edge, drop_edge;

    tbl[0] = mk(1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    tbl[1] = mk(0, 1, 5, -3, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[2] = mk(0, 0, 0, 0,  0, 0, 1, 0,  1, 0, 0, 0);
    tbl[3] = mk(0, 0, 0, 0,  1, 5, 0, 0,  1, 0, 0, 0);
    tbl[4] = mk(0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 1, -3);
    tbl[5] = mk(0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, -3);

    for (int b = 0; b < 2; b++)
      for (int a = 0; a < WORDS; a++) mdl_mem[b][a] = UNK;
    idle_inputs();
    rst = 1'b1;
    model_reset();

    // Directed table: reset, write, swap, read with its latency and hold.
    for (int i = 0; i < 6; i++) begin
      rst = tbl[i].rst; mem_we = tbl[i].we; mem_addr = AW'(tbl[i].addr);
      write_data = DW'(tbl[i].wdata); read_en = tbl[i].ren; read_addr = AW'(tbl[i].raddr);
      swap = tbl[i].swp; clear = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_fill_sel", i), fill_sel, tbl[i].e_fill);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_read_valid", i), read_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_read_data", i), read_data, tbl[i].e_data);
    end
    idle_inputs();

    // Clear of a saturated fill bank; port writes during clear must be dropped.
    for (int a = 0; a < WORDS; a++) begin
      mem_we = 1; mem_addr = AW'(a); write_data = 16'sh7FFF;
      tick();
    end
    idle_inputs();
    clear = 1; tick(); clear = 0;
    busy_cnt = busy ? 1 : 0;
    for (int k = 0; k < WORDS + 4; k++) begin
      mem_we = busy; mem_addr = AW'($urandom); write_data = 16'sh1234;
      tick();
      if (busy) busy_cnt++;
    end
    chk("clear_busy_cycles", busy_cnt, WORDS);
    idle_inputs();
    swap = 1; tick(); swap = 0;
    chk("clear_swap_fill_sel", fill_sel, 0);
    vcnt = 0; nz = 0;
    for (int a = 0; a < WORDS + OR + 1; a++) begin
      read_en = (a < WORDS); read_addr = AW'(a);
      tick();
      if (read_valid) begin
        vcnt++;
        if (read_data != 0) nz++;
      end
    end
    chk("clear_read_count", vcnt, WORDS);
    chk("clear_read_nonzero", nz, 0);
    idle_inputs();

    // Swap requested at clear cycle 10 is held until the clear finishes.
    clear = 1; tick(); clear = 0;
    f0 = fill_sel; prev_f = fill_sel; toggles = 0; toggle_edge = -1; drop_edge = -1;
    for (int k = 1; k <= WORDS + 4; k++) begin
      swap = (k == 10);
      tick();
      if (fill_sel != prev_f) toggles++;
      prev_f = fill_sel;
      if (fill_sel != f0 && toggle_edge < 0) toggle_edge = k;
      if (!busy && drop_edge < 0) drop_edge = k;
    end
    swap = 0;
    chk("swapclr_toggle_edge", toggle_edge, WORDS + 1);
    chk("swapclr_busy_drop_edge", drop_edge, WORDS + 1);
    chk("swapclr_toggles", toggles, 1);

    // Concurrent fill writes and compute reads at the same addresses.
    for (int a = 0; a < WORDS; a++) begin
      mem_we = 1; mem_addr = AW'(a); write_data = DW'($urandom);
      tick();
    end
    idle_inputs();
    swap = 1; tick(); swap = 0;
    vcnt = 0;
    for (int a = 0; a < WORDS + OR + 1; a++) begin
      mem_we = (a < WORDS); mem_addr = AW'(a); write_data = DW'($urandom);
      read_en = (a < WORDS); read_addr = AW'(a);
      tick();
      if (read_valid) vcnt++;
    end
    chk("concur_read_count", vcnt, WORDS);
    idle_inputs();

    // Reset in the middle of a clear, then a full clear right after release.
    clear = 1; tick(); clear = 0;
    for (int k = 1; k <= 100; k++) tick();
    #2;
    async_reset_check();
    clear = 1; tick(); clear = 0;
    busy_cnt = busy ? 1 : 0;
    for (int k = 0; k < WORDS + 4; k++) begin
      tick();
      if (busy) busy_cnt++;
    end
    chk("rstclr_busy_cycles", busy_cnt, WORDS);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      mem_we = $urandom_range(0, 1); mem_addr = AW'($urandom); write_data = DW'($urandom);
      read_en = $urandom_range(0, 1); read_addr = AW'($urandom);
      swap = ($urandom_range(0, 49) == 0);
      clear = ($urandom_range(0, 1499) == 0);
      tick();
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gobou_mem_img_pp.md
GOBOU_MEM_IMG_PP -- requirements
Module: gobou_mem_img_pp

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, data word width (signed).
REQ-002 SHALL have parameter IMGSIZE, default 12, address width; each bank holds WORDS = 2**IMGSIZE words.
REQ-003 SHALL have parameter OUTREG, default 1, extra output register stages (0 or 1).
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port mem_we, input, 1, write strobe into fill bank.
REQ-007 SHALL have port mem_addr, input, IMGSIZE, fill-side write address.
REQ-008 SHALL have port write_data, input, DWIDTH signed, fill-side write data.
REQ-009 SHALL have port read_en, input, 1, read request on compute bank.
REQ-010 SHALL have port read_addr, input, IMGSIZE, compute-side read address.
REQ-011 SHALL have port read_data, output, DWIDTH signed, compute-side read result.
REQ-012 SHALL have port read_valid, output, 1, read_data qualifier.
REQ-013 SHALL have port swap, input, 1, one-cycle request to exchange fill/compute banks.
REQ-014 SHALL have port clear, input, 1, one-cycle request to zero the fill bank.
REQ-015 SHALL have port busy, output, 1, high while clear sequence runs or swap pending.
REQ-016 SHALL have port fill_sel, output, 1, index of current fill bank (compute bank = ~fill_sel).

Function
REQ-017 SHALL contain two banks of WORDS x DWIDTH; fill bank written only, compute bank read only.
REQ-018 SHALL, in IDLE with mem_we=1, write write_data to fill bank[mem_addr] at that edge.
REQ-019 SHALL sample read_addr and bank select (~fill_sel) at the read_en edge; read_data/read_valid appear 1+OUTREG cycles later, aligned.
REQ-020 SHALL hold read_data at last value when read_valid=0; read_valid high exactly one cycle per accepted read_en; back-to-back reads give one result per cycle.
REQ-021 SHALL implement FSM IDLE/CLEAR: clear=1 in IDLE -> CLEAR with counter=0; each CLEAR cycle writes 0 to fill bank[counter], counter+1; after writing WORDS-1 -> IDLE; clear takes exactly WORDS cycles.
REQ-022 SHALL ignore mem_we while in CLEAR (no fill-bank write from port).
REQ-023 SHALL ignore clear asserted while already in CLEAR (no restart).
REQ-024 SHALL, on swap=1 in IDLE with no clear that cycle, toggle fill_sel at that edge.
REQ-025 SHALL, on swap during CLEAR or coincident with clear, latch swap pending; toggle fill_sel the edge after CLEAR ends; multiple pending swaps collapse to one.
REQ-026 SHALL drive busy = (state==CLEAR) | pending.
REQ-027 SHALL serve compute-bank reads unaffected by CLEAR; reads in flight during a swap return data from the bank sampled at read_en.
REQ-028 SHALL give a same-cycle write to fill bank and read of compute bank at equal address independent results (different banks).

Reset
REQ-029 SHALL, on rst asserted (asynchronously), force state=IDLE, counter=0, pending=0, fill_sel=0, busy=0, read_valid=0, read_data=0, flush read pipeline.
REQ-030 SHALL, on rst mid-CLEAR, abort clearing; partially cleared contents are left as-is; memory array itself is not reset.
REQ-031 SHALL, after rst deasserts, accept requests on the first rising edge.

Verification
REQ-032 SHALL verify reset: rst pulse -> fill_sel=0, busy=0, read_valid=0, read_data=0.
REQ-033 SHALL verify fill+swap+read: write bank0[5]=-3, swap, read_en addr 5 -> read_valid after 1+OUTREG cycles, read_data=-3, fill_sel=1.
REQ-034 SHALL verify clear: fill bank all 0x7FFF, clear -> busy high exactly WORDS cycles, mem_we during clear ignored; after swap all reads return 0.
REQ-035 SHALL verify swap-during-clear: swap at clear cycle 10 -> fill_sel unchanged until cycle after CLEAR ends, then toggles once; busy drops same edge.
REQ-036 SHALL verify concurrency: writes to fill bank addr 0..WORDS-1 while streaming reads of compute bank -> compute data unchanged, one valid per read_en.
REQ-037 SHALL verify reset mid-clear: rst at clear cycle 100 -> IDLE, busy=0; new clear runs full WORDS cycles.
